rtc_bcd_timebase: RTL and testbench



---
 rtl/rtc_bcd_timebase.sv | 144 ++++++++++++++
 tb/tb_rtc_bcd_timebase.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rtc_bcd_timebase.sv
// rtc_bcd_timebase: parametrised BCD cascade timebase.
// NUM_DIGITS 4-bit BCD digits. Digit k counts 0..ROLLOVER nibble k, and the
// digits ripple carry (or borrow) into each other within one clock.
// Supports up/down counting, a synchronous clear, and a clamped preset load.
// o_count is a display copy of the live count that can be frozen.
// Optional feature macro: RTC_LAP_EN adds a split-time lap capture register.
// If RTC_LAP_EN is not defined, o_lapcount is tied to zero.
module rtc_bcd_timebase #(
    parameter int          NUM_DIGITS = 6,
    parameter logic [31:0] ROLLOVER   = 32'h0059_5999,
    parameter int          CW         = 4 * NUM_DIGITS
) (
    input  logic          i_rtcclk,
    input  logic          i_reset_n,
    input  logic          i_countenb,
    input  logic          i_countinit,
    input  logic          i_latchcount,
    input  logic          i_dir,
    input  logic          i_load,
    input  logic [CW-1:0] i_loadval,
    input  logic          i_lap,
    output logic [CW-1:0] o_count,
    output logic          o_rolloverflag,
    output logic          o_zeroflag,
    output logic [CW-1:0] o_lapcount
);

    // Per-digit terminal values, packed the same way as the count.
    localparam logic [CW-1:0] MAX_C = ROLLOVER[CW-1:0];

    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] disp_q, disp_d;
    logic          roll_q, roll_d;
    logic          zero_q, zero_d;
    logic [CW-1:0] step_c;
    logic [CW-1:0] load_c;
    logic          carry_c;

    // One up/down step: the carry/borrow ripples from digit 0 upward.
    // The final carry_c value is set only when every digit wrapped.
    // NOTE: every output gets a default before the branches, so no latch is inferred.
    always_comb begin
        step_c  = count_q;
        carry_c = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (carry_c) begin
                if (!i_dir) begin
                    if (count_q[4*k +: 4] >= MAX_C[4*k +: 4]) begin
                        step_c[4*k +: 4] = 4'd0;
                    end else begin
                        step_c[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
                        carry_c          = 1'b0;
                    end
                end else begin
                    if (count_q[4*k +: 4] == 4'd0) begin
                        step_c[4*k +: 4] = MAX_C[4*k +: 4];
                    end else begin
                        step_c[4*k +: 4] = count_q[4*k +: 4] - 4'd1;
                        carry_c          = 1'b0;
                    end
                end
            end
        end
    end

    // Preset value with each digit clamped to its terminal value.
    // Clamping here keeps every digit a legal BCD value.
    always_comb begin
        load_c = i_loadval;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (i_loadval[4*k +: 4] > MAX_C[4*k +: 4]) begin
                load_c[4*k +: 4] = MAX_C[4*k +: 4];
            end
        end
    end

    // Next-state selection: init beats load, and load beats a count step.
    // The display copy and the zero flag both use the next live count.
    always_comb begin
        count_d = count_q;
        roll_d  = 1'b0;
        if (i_countinit) begin
            count_d = '0;
        end else if (i_load) begin
            count_d = load_c;
        end else if (i_countenb) begin
            count_d = step_c;
            roll_d  = carry_c;
        end
        disp_d = i_latchcount ? count_d : disp_q;
        zero_d = (count_d == '0);
    end

    // Live count, display copy and flags; reset clears them without the clock.
    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge i_rtcclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_q <= '0;
            disp_q  <= '0;
            roll_q  <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            disp_q  <= disp_d;
            roll_q  <= roll_d;
            zero_q  <= zero_d;
        end
    end

    assign o_count        = disp_q;
    assign o_rolloverflag = roll_q;
    assign o_zeroflag     = zero_q;

`ifdef RTC_LAP_EN
    logic [CW-1:0] lap_q, lap_d;

    // Lap capture of the next live count; it captures even while the display is frozen.
    always_comb begin
        lap_d = lap_q;
        if (i_countinit) begin
            lap_d = '0;
        end else if (i_lap) begin
            lap_d = count_d;
        end
    end

    // Lap register, cleared asynchronously along with the count.
    always_ff @(posedge i_rtcclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            lap_q <= '0;
        end else begin
            lap_q <= lap_d;
        end
    end

    assign o_lapcount = lap_q;
`else
    // The lap strobe has no effect in this build.
    logic unused_lap;
    assign unused_lap = i_lap;
    assign o_lapcount = '0;
`endif

endmodule

// File: tb/tb_rtc_bcd_timebase.sv
// Directed test of rtc_bcd_timebase with a scoreboard.
// The driver pushes hand-computed expectations into a queue.
// A monitor compares the DUT outputs against them at each falling edge.
module tb_rtc_bcd_timebase;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, dir, init, load, latch, lap;
    logic [23:0] lv;
    logic [23:0] o_count, o_lapcount;
    logic        o_roll, o_zero;

    rtc_bcd_timebase dut (
        .i_rtcclk      (clk),
        .i_reset_n     (rst_n),
        .i_countenb    (en),
        .i_countinit   (init),
        .i_latchcount  (latch),
        .i_dir         (dir),
        .i_load        (load),
        .i_loadval     (lv),
        .i_lap         (lap),
        .o_count       (o_count),
        .o_rolloverflag(o_roll),
        .o_zeroflag    (o_zero),
        .o_lapcount    (o_lapcount)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [23:0] cnt;
        logic        roll;
        logic        zero;
        logic [23:0] lapv;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // The lap register exists only when RTC_LAP_EN is defined.
    function automatic logic [23:0] lapx(input logic [23:0] v);
`ifdef RTC_LAP_EN
        return v;
`else
        return 24'h0;
`endif
    endfunction

    task automatic expect_out(input string name, input logic [23:0] cnt, input logic roll,
                              input logic zero, input logic [23:0] lapv);
        exp_t e;
        e.name = name;
        e.cnt  = cnt;
        e.roll = roll;
        e.zero = zero;
        e.lapv = lapv;
        sb_q.push_back(e);
    endtask

    // Apply one cycle of inputs, then return 1 ns after the active edge.
    task automatic cyc(input logic e_en, input logic e_dir, input logic e_init, input logic e_load,
                       input logic e_latch, input logic e_lap, input logic [23:0] e_lv);
        en    = e_en;
        dir   = e_dir;
        init  = e_init;
        load  = e_load;
        latch = e_latch;
        lap   = e_lap;
        lv    = e_lv;
        @(posedge clk);
        #1;
    endtask

    task automatic up(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 1, 0, 24'h0);
    endtask

    // Monitor: compare the outputs against one expectation per falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.name, ".count"}, {8'h0, o_count},    {8'h0, e.cnt});
                check({e.name, ".roll"},  {31'h0, o_roll},    {31'h0, e.roll});
                check({e.name, ".zero"},  {31'h0, o_zero},    {31'h0, e.zero});
                check({e.name, ".lap"},   {8'h0, o_lapcount}, {8'h0, e.lapv});
            end
        end
    end

    // Driver
    initial begin
        rst_n = 1'b0;
        en = 0; dir = 0; init = 0; load = 0; latch = 0; lap = 0; lv = '0;
        #2;
        expect_out("reset", 24'h000000, 0, 1, 24'h0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Count up from zero.
        cyc(1, 0, 0, 0, 1, 0, 24'h0);   expect_out("up1",  24'h000001, 0, 0, 24'h0);
        up(18);
        cyc(1, 0, 0, 0, 1, 0, 24'h0);   expect_out("up20", 24'h000020, 0, 0, 24'h0);

        // Wrap when counting up.
        cyc(0, 0, 0, 1, 1, 0, 24'h595998); expect_out("load",       24'h595998, 0, 0, 24'h0);
        cyc(1, 0, 0, 0, 1, 0, 24'h0);      expect_out("up_max",     24'h595999, 0, 0, 24'h0);
        cyc(1, 0, 0, 0, 1, 0, 24'h0);      expect_out("wrap_up",    24'h000000, 1, 1, 24'h0);
        cyc(0, 0, 0, 0, 1, 0, 24'h0);      expect_out("roll_clear", 24'h000000, 0, 1, 24'h0);

        // Wrap when counting down from zero.
        cyc(1, 1, 0, 0, 1, 0, 24'h0);      expect_out("wrap_down",  24'h595999, 1, 0, 24'h0);
        cyc(1, 1, 0, 0, 1, 0, 24'h0);      expect_out("down",       24'h595998, 0, 0, 24'h0);

        // Borrow and carry ripple across several digits.
        cyc(0, 0, 0, 1, 1, 0, 24'h010000); expect_out("load2",  24'h010000, 0, 0, 24'h0);
        cyc(1, 1, 0, 0, 1, 0, 24'h0);      expect_out("borrow", 24'h005999, 0, 0, 24'h0);
        cyc(1, 0, 0, 0, 1, 0, 24'h0);      expect_out("carry",  24'h010000, 0, 0, 24'h0);

        // Display freeze while the live count keeps running.
        cyc(0, 0, 1, 0, 1, 0, 24'h0);      expect_out("init",   24'h000000, 0, 1, 24'h0);
        up(9);
        cyc(1, 0, 0, 0, 1, 0, 24'h0);      expect_out("up10",   24'h000010, 0, 0, 24'h0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0, 24'h0);
        cyc(1, 0, 0, 0, 0, 0, 24'h0);      expect_out("frozen",  24'h000010, 0, 0, 24'h0);
        cyc(1, 0, 0, 0, 1, 0, 24'h0);      expect_out("relatch", 24'h000016, 0, 0, 24'h0);

        // Load clamping and edge priority.
        cyc(0, 0, 0, 1, 1, 0, 24'h7F9999); expect_out("clamp",     24'h595999, 0, 0, 24'h0);
        cyc(1, 0, 1, 1, 1, 0, 24'h123456); expect_out("init_prio", 24'h000000, 0, 1, 24'h0);
        cyc(1, 0, 0, 1, 1, 0, 24'h000100); expect_out("load_prio", 24'h000100, 0, 0, 24'h0);

        // Lap capture.
        cyc(0, 0, 1, 0, 1, 0, 24'h0);
        up(41);
        cyc(1, 0, 0, 0, 1, 0, 24'h0);      expect_out("up42",     24'h000042, 0, 0, 24'h0);
        cyc(0, 0, 0, 0, 0, 1, 24'h0);      expect_out("lap_cap",  24'h000042, 0, 0, lapx(24'h000042));
        up(7);
        cyc(1, 0, 0, 0, 1, 0, 24'h0);      expect_out("lap_hold", 24'h000050, 0, 0, lapx(24'h000042));
        cyc(0, 0, 1, 0, 1, 0, 24'h0);      expect_out("lap_init", 24'h000000, 0, 1, 24'h0);
        up(2);
        cyc(1, 0, 0, 0, 1, 1, 24'h0);      expect_out("lap_live", 24'h000003, 0, 0, lapx(24'h000003));

        // Assert reset between clock edges while the count is running.
        cyc(1, 0, 0, 0, 1, 1, 24'h0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async_rst", 24'h000000, 0, 1, 24'h0);
        @(negedge clk); #1;
        rst_n = 1'b1;

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk); #1;
        end
        check("drain", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
